// File: rtl/div_unit_iter_pkg.sv
// Shared types and decode helpers for the iterative integer divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

  typedef struct packed {
    logic    valid;
    div_op_t op;
  } div_dec_t;

  // funct3[2] marks a divide op; the low two bits map directly onto div_op_t.
  function automatic div_dec_t decode_funct3(input logic [2:0] f3);
    div_dec_t d;
    d.valid = f3[2];
    d.op    = div_op_t'(f3[1:0]);
    return d;
  endfunction

  function automatic logic is_signed_op(input div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem_op(input div_op_t op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_unit_iter_step.sv
// Combinational BPC-bit restoring division step on unsigned magnitudes.
module div_step #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned BPC  = 1
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_dvs,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0]   w_tmp;
  logic [XLEN-1:0] w_r;
  logic [XLEN-1:0] w_q;

  // Shift one dividend bit into the remainder, trial-subtract, keep on no borrow.
  always_comb begin
    w_tmp = '0;
    w_r   = i_rem;
    w_q   = i_quo;
    for (int unsigned i = 0; i < BPC; i++) begin
      w_tmp = {w_r, w_q[XLEN-1]};
      w_q   = {w_q[XLEN-2:0], 1'b0};
      if (w_tmp >= {1'b0, i_dvs}) begin
        w_tmp  = w_tmp - {1'b0, i_dvs};
        w_q[0] = 1'b1;
      end
      w_r = w_tmp[XLEN-1:0];
    end
    o_rem = w_r;
    o_quo = w_q;
  end

endmodule

// File: rtl/div_unit_iter.sv
// Multi-cycle RV32M/RV64M divider: DIV/DIVU/REM/REMU with valid/ready and flush.
module div_unit_iter
  import div_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BPC       = 1,
  parameter bit          FAST_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            mul_ext_valid,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int unsigned STEPS = XLEN / BPC;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t       r_state;
  div_op_t          r_op;
  logic [XLEN-1:0]  r_rs1, r_rs2;
  logic [XLEN-1:0]  r_rem, r_quo, r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_qneg, r_rneg, r_special;
  logic [XLEN-1:0]  r_spec_res;
  logic [XLEN-1:0]  r_result;
  logic             r_illegal, r_out_valid, r_in_ready;

  div_dec_t         w_dec;
  logic             w_accept, w_sgn, w_rs1_neg, w_rs2_neg, w_div0, w_ovf;
  logic [XLEN-1:0]  w_abs1, w_abs2, w_spec_res, w_fix_res;
  logic [XLEN-1:0]  w_st_rem, w_st_quo, w_st_dvs, w_nx_rem, w_nx_quo;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign illegal   = r_illegal;

  assign w_dec     = decode_funct3(funct3);
  assign w_accept  = in_valid & mul_ext_valid & r_in_ready;
  assign w_sgn     = is_signed_op(r_op);
  assign w_rs1_neg = w_sgn & r_rs1[XLEN-1];
  assign w_rs2_neg = w_sgn & r_rs2[XLEN-1];
  assign w_abs1    = w_rs1_neg ? (~r_rs1 + XLEN'(1)) : r_rs1;
  assign w_abs2    = w_rs2_neg ? (~r_rs2 + XLEN'(1)) : r_rs2;
  assign w_div0    = (r_rs2 == '0);
  assign w_ovf     = w_sgn & (r_rs1 == MIN_INT) & (r_rs2 == '1);

  // Architectural results for divide-by-zero and signed overflow.
  always_comb begin
    w_spec_res = '0;
    if (w_div0) begin
      w_spec_res = is_rem_op(r_op) ? r_rs1 : '1;
    end else if (w_ovf) begin
      w_spec_res = is_rem_op(r_op) ? '0 : r_rs1;
    end
  end

  // Sign-correct the magnitude result and pick quotient or remainder.
  always_comb begin
    w_fix_res = '0;
    if (r_special) begin
      w_fix_res = r_spec_res;
    end else if (is_rem_op(r_op)) begin
      w_fix_res = r_rneg ? (~r_rem + XLEN'(1)) : r_rem;
    end else begin
      w_fix_res = r_qneg ? (~r_quo + XLEN'(1)) : r_quo;
    end
  end

  // PREP feeds the fresh magnitudes into the step so the first quotient bits resolve there.
  always_comb begin
    w_st_rem = r_rem;
    w_st_quo = r_quo;
    w_st_dvs = r_dvs;
    if (r_state == PREP) begin
      w_st_rem = '0;
      w_st_quo = w_abs1;
      w_st_dvs = w_abs2;
    end
  end

  div_step #(
    .XLEN (XLEN),
    .BPC  (BPC)
  ) u_step (
    .i_rem (w_st_rem),
    .i_quo (w_st_quo),
    .i_dvs (w_st_dvs),
    .o_rem (w_nx_rem),
    .o_quo (w_nx_quo)
  );

  // Control FSM and datapath registers; flush overrides every other event.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_op        <= DIV;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_special   <= 1'b0;
      r_spec_res  <= '0;
      r_result    <= '0;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (flush) begin
      r_state     <= IDLE;
      r_result    <= '0;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (!w_dec.valid) begin
              r_result    <= '0;
              r_illegal   <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_op      <= w_dec.op;
              r_rs1     <= rs1;
              r_rs2     <= rs2;
              r_illegal <= 1'b0;
              r_state   <= PREP;
            end
          end
        end
        PREP: begin
          r_qneg     <= w_rs1_neg ^ w_rs2_neg;
          r_rneg     <= w_rs1_neg;
          r_special  <= w_div0 | w_ovf;
          r_spec_res <= w_spec_res;
          if (FAST_ZERO && (w_div0 || w_ovf)) begin
            r_result    <= w_spec_res;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_rem   <= w_nx_rem;
            r_quo   <= w_nx_quo;
            r_dvs   <= w_abs2;
            r_cnt   <= CNT_W'(STEPS - 1);
            r_state <= CALC;
          end
        end
        CALC: begin
          r_rem <= w_nx_rem;
          r_quo <= w_nx_quo;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_result    <= w_fix_res;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/div_unit_iter.md
Name: div_unit_iter

Overview:
- Parametrised multi-cycle integer divider for the RV32IM/RV64IM M-extension path.
- Decodes funct3 internally to DIV, DIVU, REM or REMU, then runs a radix-2^BPC restoring division.
- Sits beside the multiplier in the execute stage and talks to the control FSM over valid/ready handshakes.
- Adds what the combinational decoder lacked: width/throughput parameters, RISC-V divide-by-zero and overflow semantics, back-pressure and flush.

Parameters:
- XLEN, 32, operand and result width; allowed values 32 or 64.
- BPC, 1, quotient bits resolved per CALC cycle; allowed values 1, 2 or 4; must divide XLEN.
- FAST_ZERO, 1, when 1, divide-by-zero and signed overflow bypass CALC.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- funct3  in  3  instruction funct3 field.
- mul_ext_valid  in  1  M-extension op qualifier; a request is taken only when in_valid & mul_ext_valid & in_ready.
- rs1  in  XLEN  dividend.
- rs2  in  XLEN  divisor.
- flush  in  1  abort the in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  quotient or remainder.
- illegal  out  1  accepted funct3[2]==0 (not a divide op); qualified by out_valid.

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, in_ready=1, out_valid=0, result=0, illegal=0, all datapath registers 0.
- States and transitions:
  - IDLE: in_ready=1.
    - On accept with funct3[2]==0 → DONE with result=0, illegal=1.
    - Otherwise latch the op, rs1 and rs2 → PREP.
  - PREP: for signed ops, take |rs1| and |rs2|; record quotient sign = sign(rs1)^sign(rs2) and remainder sign = sign(rs1).
    - Divisor==0: result = all-ones for DIV/DIVU, rs1 for REM/REMU.
    - Signed op with rs1==MIN_INT and rs2==-1: result = rs1 for DIV, 0 for REM.
    - These special cases, when FAST_ZERO=1 → DONE; otherwise → CALC.
    - All other cases → CALC with counter = XLEN/BPC-1.
  - CALC: per cycle, BPC restoring steps; shift the remainder/quotient pair, trial-subtract, set quotient bit when no borrow.
    - Counter decrements each cycle; counter==0 → FIX.
    - With FAST_ZERO=0 the special cases still run through CALC and are overridden in FIX.
  - FIX: apply sign correction (two's-complement negate when the sign flag is set); select quotient or remainder → DONE.
  - DONE: out_valid=1 and result/illegal held stable while out_ready=0. On out_ready=1 → IDLE.
- in_ready=1 only in IDLE; there is no accept in the same cycle as the DONE handshake.
- Latency, counted in edges from the accepting edge to out_valid high:
  - XLEN/BPC+2 for the normal path.
  - 2 for the fast path.
  - 1 for an illegal op.
- flush: synchronous, highest priority over all other events.
  - In any state → IDLE on the next edge, out_valid=0, no result delivered.
  - flush together with an accept in IDLE discards the request.
- Results are XLEN-bit wrap-around; no other exceptions are raised.
- X-propagation: result must never be X; the invalid decode drives 0.

Decomposition:
- Package div_pkg holds:
  - div_op_t enum, 2 bits: DIV=0, DIVU=1, REM=2, REMU=3. These replace the DIV_OP_* defines.
  - div_state_t enum: IDLE, PREP, CALC, FIX, DONE.
  - Function decode_funct3 returning {valid, div_op_t}.
- Sub-module div_step: combinational BPC-bit restoring step.
  - Inputs: remainder, quotient, divisor.
  - Outputs: next remainder, next quotient.
  - Instantiated once in CALC.

Test Plan:
- DIV, XLEN=32, BPC=1: rs1=20, rs2=0xFFFFFFFD (-3) → result=0xFFFFFFFA; out_valid on edge 34 after accept. REM on the same operands → 2.
- DIVU rs1=0xFFFFFFFF, rs2=0 → 0xFFFFFFFF with latency 2 (FAST_ZERO=1). REMU on the same operands → 0xFFFFFFFF. With FAST_ZERO=0 → same values with latency 34.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF → 0x80000000. REM on the same operands → 0.
- BPC=2: DIVU 1000/7 → 142, latency 18. BPC=4: REMU 1000/7 → 6, latency 10. Random signed sweep checked against a reference model for XLEN=64.
- Back-pressure: hold out_ready=0 for 5 cycles → result stable, in_ready=0. Then out_ready=1 → IDLE and in_ready=1 on the next edge.
- flush at CALC cycle 10 → out_valid never rises; the next request DIV 7/2 returns 3. Asserting resetn=0 mid-CALC clears out_valid immediately with no clock edge. funct3=3'b000 → illegal=1, result=0, latency 1.
